// File: rtl/calc_pkg.sv
// Shared types and default sizing for the slider calculator.
package calc_pkg;

    localparam int OPERAND_W_DEF   = 14;
    localparam int RESULT_W_DEF    = 27;
    localparam int MAX_OPERAND_DEF = 9999;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_ENTER_B = 3'd1,
        ST_EXEC    = 3'd2,
        ST_RESULT  = 3'd3,
        ST_ERROR   = 3'd4
    } state_e;

    // Multiply and divide go through the iterative unit; add/sub do not.
    function automatic logic op_is_iterative(input op_e o);
        return (o == OP_MUL) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Shared shift-add multiplier / restoring divider.
// One bit per cycle, finishing exactly OPERAND_W cycles after start.
// 'done' and 'quo_prod' are combinational and describe the step that
// completes on the coming edge, so the caller can capture the answer in
// the final iteration cycle.
// With CALC_REMAINDER_EN defined, a remainder output is also provided.
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int OPERAND_W = OPERAND_W_DEF,
    parameter int RESULT_W  = RESULT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode_div,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
`ifdef CALC_REMAINDER_EN
    output logic [OPERAND_W-1:0] remainder,
`endif
    output logic                 done,
    output logic [RESULT_W-1:0]  quo_prod
);

    localparam int CW = $clog2(OPERAND_W);
    localparam int PW = 2 * OPERAND_W;

    logic                 active;
    logic                 mode_q;
    logic [CW-1:0]        cnt;
    logic [OPERAND_W-1:0] work;
    logic [PW-1:0]        acc;
    logic [PW-2:0]        mcand;
    logic [OPERAND_W-1:0] rem;
    logic [OPERAND_W-1:0] divisor;

    logic [OPERAND_W:0]   shifted;
    logic                 div_ge;
    logic [OPERAND_W-1:0] diff;
    logic [OPERAND_W-1:0] rem_next;
    logic [PW-1:0]        acc_next;
    logic [PW-2:0]        mcand_next;
    logic [OPERAND_W-1:0] work_next;

    // One iteration step: work holds the multiplier (mul) or the dividend
    // being shifted into the quotient (div).
    always_comb begin
        shifted    = {rem, work[OPERAND_W-1]};
        div_ge     = shifted >= {1'b0, divisor};
        diff       = shifted[OPERAND_W-1:0] - divisor;
        rem_next   = div_ge ? diff : shifted[OPERAND_W-1:0];
        acc_next   = work[0] ? (acc + PW'(mcand)) : acc;
        mcand_next = {mcand[PW-3:0], 1'b0};
        work_next  = mode_q ? {work[OPERAND_W-2:0], div_ge}
                            : {1'b0, work[OPERAND_W-1:1]};
    end

    assign done     = active && (cnt == CW'(OPERAND_W - 1));
    assign quo_prod = mode_q ? RESULT_W'(work_next) : acc_next[RESULT_W-1:0];
`ifdef CALC_REMAINDER_EN
    assign remainder = rem_next;
`endif

    // Load operands on start, then advance one bit per cycle until done.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            mode_q  <= 1'b0;
            cnt     <= '0;
            work    <= '0;
            acc     <= '0;
            mcand   <= '0;
            rem     <= '0;
            divisor <= '0;
        end else if (abort) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            mode_q  <= mode_div;
            work    <= mode_div ? a : b;
            mcand   <= (PW-1)'(a);
            acc     <= '0;
            rem     <= '0;
            divisor <= b;
        end else if (active) begin
            work  <= work_next;
            acc   <= acc_next;
            mcand <= mcand_next;
            rem   <= rem_next;
            cnt   <= cnt + CW'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Top-level controller for the slider calculator: operand entry, range
// checking, add/sub, and sequencing of the shared iterative mul/div unit.
// Optional feature macro: CALC_REMAINDER_EN adds the remainder output and
// the btn_op_toggle input to flip the display between quotient and remainder.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int OPERAND_W   = OPERAND_W_DEF,
    parameter int MAX_OPERAND = MAX_OPERAND_DEF,
    parameter int RESULT_W    = RESULT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_next,
    input  logic                 btn_clear,
    input  logic [1:0]           op,
    input  logic [OPERAND_W-1:0] number_1,
    input  logic [OPERAND_W-1:0] number_2,
`ifdef CALC_REMAINDER_EN
    input  logic                 btn_op_toggle,
    output logic [OPERAND_W-1:0] remainder,
`endif
    output logic                 write_number_select,
    output logic                 operand_clr,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [RESULT_W-1:0]  result,
    output logic                 result_neg,
    output logic [RESULT_W-1:0]  disp_value
);

    state_e               state;
    op_e                  op_q;
    op_e                  op_in;
    logic [OPERAND_W-1:0] a_q;
    logic [OPERAND_W-1:0] b_q;
    logic                 operands_bad;
    logic                 iter_start;
    logic                 iter_done;
    logic [RESULT_W-1:0]  iter_quo_prod;
    logic [RESULT_W-1:0]  addsub_value;
    logic                 addsub_neg;
`ifdef CALC_REMAINDER_EN
    logic [OPERAND_W-1:0] iter_remainder;
    logic                 show_rem;
`endif

    assign op_in        = op_e'(op);
    assign operands_bad = (number_1 > OPERAND_W'(MAX_OPERAND))
                       || (number_2 > OPERAND_W'(MAX_OPERAND))
                       || ((op_in == OP_DIV) && (number_2 == '0));
    assign iter_start   = (state == ST_ENTER_B) && btn_next && !btn_clear
                       && !operands_bad && op_is_iterative(op_in);

    calc_iter_unit #(
        .OPERAND_W (OPERAND_W),
        .RESULT_W  (RESULT_W)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (iter_start),
        .abort     (btn_clear),
        .mode_div  (op_in == OP_DIV),
        .a         (number_1),
        .b         (number_2),
`ifdef CALC_REMAINDER_EN
        .remainder (iter_remainder),
`endif
        .done      (iter_done),
        .quo_prod  (iter_quo_prod)
    );

    // Single-cycle add, or magnitude-and-sign subtract, of the latched operands.
    always_comb begin
        addsub_value = '0;
        addsub_neg   = 1'b0;
        if (op_q == OP_ADD) begin
            addsub_value = RESULT_W'(a_q) + RESULT_W'(b_q);
        end else if (a_q >= b_q) begin
            addsub_value = RESULT_W'(a_q - b_q);
        end else begin
            addsub_value = RESULT_W'(b_q - a_q);
            addsub_neg   = 1'b1;
        end
    end

    // Main FSM with all user-visible flags registered; clear overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_ENTER_A;
            write_number_select <= 1'b0;
            operand_clr         <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            result              <= '0;
            result_neg          <= 1'b0;
            op_q                <= OP_ADD;
            a_q                 <= '0;
            b_q                 <= '0;
`ifdef CALC_REMAINDER_EN
            remainder           <= '0;
            show_rem            <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            operand_clr <= 1'b0;
            if (btn_clear) begin
                state               <= ST_ENTER_A;
                write_number_select <= 1'b0;
                operand_clr         <= 1'b1;
                busy                <= 1'b0;
                error               <= 1'b0;
                result              <= '0;
                result_neg          <= 1'b0;
`ifdef CALC_REMAINDER_EN
                remainder           <= '0;
                show_rem            <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_ENTER_A: begin
                        if (btn_next) begin
                            state               <= ST_ENTER_B;
                            write_number_select <= 1'b1;
                        end
                    end
                    ST_ENTER_B: begin
                        if (btn_next) begin
                            a_q  <= number_1;
                            b_q  <= number_2;
                            op_q <= op_in;
`ifdef CALC_REMAINDER_EN
                            remainder <= '0;
                            show_rem  <= 1'b0;
`endif
                            if (operands_bad) begin
                                state      <= ST_ERROR;
                                error      <= 1'b1;
                                result     <= '0;
                                result_neg <= 1'b0;
                            end else begin
                                state <= ST_EXEC;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ST_EXEC: begin
                        if (!op_is_iterative(op_q)) begin
                            state      <= ST_RESULT;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            result     <= addsub_value;
                            result_neg <= addsub_neg;
                        end else if (iter_done) begin
                            state      <= ST_RESULT;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            result     <= iter_quo_prod;
                            result_neg <= 1'b0;
`ifdef CALC_REMAINDER_EN
                            if (op_q == OP_DIV) begin
                                remainder <= iter_remainder;
                            end
`endif
                        end
                    end
                    ST_RESULT: begin
                        if (btn_next) begin
                            state               <= ST_ENTER_A;
                            operand_clr         <= 1'b1;
                            write_number_select <= 1'b0;
`ifdef CALC_REMAINDER_EN
                            show_rem            <= 1'b0;
                        end else if (btn_op_toggle) begin
                            show_rem <= ~show_rem;
`endif
                        end
                    end
                    ST_ERROR: begin
                        if (btn_next) begin
                            state               <= ST_ENTER_A;
                            operand_clr         <= 1'b1;
                            write_number_select <= 1'b0;
                            error               <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_ENTER_A;
                    end
                endcase
            end
        end
    end

    // Display shows whatever the user is currently editing or reading.
    always_comb begin
        disp_value = '0;
        case (state)
            ST_ENTER_A: disp_value = RESULT_W'(number_1);
            ST_ENTER_B: disp_value = RESULT_W'(number_2);
`ifdef CALC_REMAINDER_EN
            ST_RESULT:  disp_value = show_rem ? RESULT_W'(remainder) : result;
`else
            ST_RESULT:  disp_value = result;
`endif
            default:    disp_value = '0;
        endcase
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: table of operations plus
// hand-written abort/reset/clear sequences; expected results are queued
// when an operation is launched and popped when done or error appears.
module tb_calc_sequencer;

    localparam int W  = 14;
    localparam int RW = 27;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [1:0]    op;
        logic [RW-1:0] res;
        logic          neg;
        logic          err;
        logic [W-1:0]  rem;
        int            lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_next = 1'b0;
    logic          btn_clear = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [W-1:0]  number_1 = '0;
    logic [W-1:0]  number_2 = '0;
    logic          write_number_select;
    logic          operand_clr;
    logic          busy;
    logic          done;
    logic          error;
    logic [RW-1:0] result;
    logic          result_neg;
    logic [RW-1:0] disp_value;
`ifdef CALC_REMAINDER_EN
    logic          btn_op_toggle = 1'b0;
    logic [W-1:0]  remainder;
`endif

    int   errors = 0;
    int   checks = 0;
    vec_t exp_q[$];
    vec_t vecs[14];

    calc_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .btn_next            (btn_next),
        .btn_clear           (btn_clear),
        .op                  (op),
        .number_1            (number_1),
        .number_2            (number_2),
`ifdef CALC_REMAINDER_EN
        .btn_op_toggle       (btn_op_toggle),
        .remainder           (remainder),
`endif
        .write_number_select (write_number_select),
        .operand_clr         (operand_clr),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .result              (result),
        .result_neg          (result_neg),
        .disp_value          (disp_value)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_next();
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
    endtask

    function automatic vec_t mk(input int a, input int b, input int o, input longint res,
                                input bit neg, input bit err, input int rem);
        vec_t v;
        v.a   = W'(a);
        v.b   = W'(b);
        v.op  = 2'(o);
        v.res = RW'(res);
        v.neg = neg;
        v.err = err;
        v.rem = W'(rem);
        v.lat = err ? 1 : ((o >= 2) ? 15 : 2);
        return v;
    endfunction

    // Reference arithmetic for randomly chosen legal operands.
    function automatic vec_t model(input int a, input int b, input int o);
        longint r;
        bit     n;
        int     rm;
        r  = 0;
        n  = 1'b0;
        rm = 0;
        case (o)
            0: r = longint'(a) + longint'(b);
            1: begin
                if (a >= b) r = a - b;
                else begin r = b - a; n = 1'b1; end
            end
            2: r = longint'(a) * longint'(b);
            default: begin r = a / b; rm = a % b; end
        endcase
        return mk(a, b, o, r, n, 1'b0, rm);
    endfunction

    // Enter both operands and launch the operation; expected result is queued.
    task automatic apply_stimulus(input vec_t v);
        number_1 = v.a;
        #1;
        check_output("disp_enter_a", disp_value, v.a);
        pulse_next();
        check_output("wns_enter_b", write_number_select, 1);
        number_2 = v.b;
        op       = v.op;
        #1;
        check_output("disp_enter_b", disp_value, v.b);
        exp_q.push_back(v);
        pulse_next();
    endtask

    // Wait (bounded) for done/error, compare against the scoreboard, return to ENTER_A.
    task automatic run_vector(input vec_t v, input int poke_k, input bit do_toggle);
        int   k;
        int   busy_cycles;
        bit   found;
        vec_t e;
        apply_stimulus(v);
        k = 1;
        busy_cycles = 0;
        found = 1'b0;
        while (!found && k <= 40) begin
            if (done || error) begin
                found = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                if (k == poke_k) pulse_next();
                else tick();
                k++;
            end
        end
        e = exp_q.pop_front();
        check_output("latency", k, e.lat);
        if (!found) begin
            btn_clear = 1'b1;
            tick();
            btn_clear = 1'b0;
            tick();
            return;
        end
        check_output("error_flag", error, e.err);
        check_output("done_flag", done, !e.err);
        check_output("result", result, e.res);
        check_output("busy_cycles", busy_cycles, e.err ? 0 : e.lat - 1);
        if (!e.err) begin
            check_output("result_neg", result_neg, e.neg);
            check_output("disp_result", disp_value, e.res);
        end
`ifdef CALC_REMAINDER_EN
        check_output("remainder", remainder, e.rem);
`endif
        tick();
        check_output("done_single", done, 0);
        check_output("result_hold", result, e.res);
`ifdef CALC_REMAINDER_EN
        if (do_toggle) begin
            btn_op_toggle = 1'b1;
            tick();
            btn_op_toggle = 1'b0;
            check_output("disp_remainder", disp_value, e.rem);
            btn_op_toggle = 1'b1;
            tick();
            btn_op_toggle = 1'b0;
            check_output("disp_quotient", disp_value, e.res);
        end
`endif
        pulse_next();
        check_output("clr_pulse", operand_clr, 1);
        check_output("wns_back_a", write_number_select, 0);
        check_output("error_cleared", error, 0);
        tick();
        check_output("clr_single", operand_clr, 0);
    endtask

    initial begin
        int done_seen;
        vecs[0]  = mk(1234, 4321, 0, 5555,     0, 0, 0);
        vecs[1]  = mk(100,  250,  1, 150,      1, 0, 0);
        vecs[2]  = mk(250,  100,  1, 150,      0, 0, 0);
        vecs[3]  = mk(7,    7,    1, 0,        0, 0, 0);
        vecs[4]  = mk(9999, 9999, 0, 19998,    0, 0, 0);
        vecs[5]  = mk(9999, 9999, 2, 99980001, 0, 0, 0);
        vecs[6]  = mk(123,  45,   2, 5535,     0, 0, 0);
        vecs[7]  = mk(1000, 7,    3, 142,      0, 0, 6);
        vecs[8]  = mk(9999, 1,    3, 9999,     0, 0, 0);
        vecs[9]  = mk(5,    9,    3, 0,        0, 0, 5);
        vecs[10] = mk(1234, 0,    3, 0,        0, 1, 0);
        vecs[11] = mk(12000, 5,   0, 0,        0, 1, 0);
        vecs[12] = mk(10,   10000, 2, 0,       0, 1, 0);
        vecs[13] = mk(0,    9999, 2, 0,        0, 0, 0);

        // Reset state
        number_1 = 14'd321;
        tick();
        tick();
        check_output("rst_wns", write_number_select, 0);
        check_output("rst_clr", operand_clr, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_error", error, 0);
        check_output("rst_result", result, 0);
        check_output("rst_neg", result_neg, 0);
        rst = 1'b0;
        tick();
        check_output("rst_disp_enter_a", disp_value, 321);

        // Table-driven operations; vector 6 also gets a btn_next pulse mid-EXEC
        for (int i = 0; i < 14; i++) begin
            run_vector(vecs[i], (i == 6) ? 3 : 0, (vecs[i].op == 2'd3) && !vecs[i].err);
        end

        // rst in the middle of a multiply
        number_1 = 14'd77;
        pulse_next();
        number_2 = 14'd88;
        op = 2'd2;
        pulse_next();
        repeat (5) tick();
        check_output("rstx_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rstx_wns", write_number_select, 0);
        check_output("rstx_clr", operand_clr, 0);
        check_output("rstx_busy", busy, 0);
        check_output("rstx_done", done, 0);
        check_output("rstx_error", error, 0);
        check_output("rstx_result", result, 0);
        check_output("rstx_neg", result_neg, 0);
        check_output("rstx_disp", disp_value, 77);
        tick();
        check_output("rstx_clr_after", operand_clr, 0);
        done_seen = 0;
        repeat (20) begin tick(); if (done) done_seen++; end
        check_output("rstx_no_done", done_seen, 0);

        // Leave a nonzero result behind, then abort a multiply at EXEC cycle 5
        run_vector(vecs[0], 0, 1'b0);
        number_1 = 14'd300;
        pulse_next();
        number_2 = 14'd200;
        op = 2'd2;
        pulse_next();
        repeat (4) tick();
        check_output("abort_busy_before", busy, 1);
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        check_output("abort_busy", busy, 0);
        check_output("abort_clr", operand_clr, 1);
        check_output("abort_wns", write_number_select, 0);
        check_output("abort_result", result, 0);
        check_output("abort_done", done, 0);
        check_output("abort_disp", disp_value, 300);
        tick();
        check_output("abort_clr_single", operand_clr, 0);
        done_seen = 0;
        repeat (20) begin tick(); if (done) done_seen++; end
        check_output("abort_no_done", done_seen, 0);

        // Clear and next together in ENTER_B: clear wins
        number_1 = 14'd11;
        pulse_next();
        number_2 = 14'd22;
        op = 2'd0;
        btn_next = 1'b1;
        btn_clear = 1'b1;
        tick();
        btn_next = 1'b0;
        btn_clear = 1'b0;
        check_output("both_clr", operand_clr, 1);
        check_output("both_wns", write_number_select, 0);
        check_output("both_busy", busy, 0);
        check_output("both_disp", disp_value, 11);
        tick();
        check_output("both_busy_after", busy, 0);
        check_output("both_done_after", done, 0);

        // Random legal operands against the reference model
        for (int i = 0; i < 8; i++) begin
            run_vector(model(int'($urandom_range(0, 9999)), int'($urandom_range(1, 9999)), i % 4),
                       0, 1'b0);
        end

        check_output("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
